// File: rtl/tff_toggle_arb.sv
// Two-requester round-robin arbiter driving a bank of T flip-flops.
// The winner's mask is applied for len+1 non-held cycles, then the pointer moves on.
module tff_toggle_arb #(
   parameter int WIDTH = 4,
   parameter int LENW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] mask0,
   input  logic [LENW-1:0]  len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] mask1,
   input  logic [LENW-1:0]  len1,
   input  logic             hold,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] T,
   output logic [WIDTH-1:0] Q,
   output logic             busy
);

   // Handshake: a request is sampled only in IDLE; the grant pulse marks the
   // first BURST cycle and requesters must not expect any other acknowledge.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_nxt;
   logic [LENW-1:0]  cnt;
   logic [LENW-1:0]  cnt_nxt;
   logic             owner;
   logic             owner_nxt;
   logic             ptr;
   logic             ptr_nxt;
   logic             gnt0_nxt;
   logic             gnt1_nxt;
   logic             win1;

   // ptr high means requester 1 wins the next tie.
   assign win1 = (req0 && req1) ? ptr : req1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         mask_q <= '0;
         cnt    <= '0;
         owner  <= 1'b0;
         ptr    <= 1'b0;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
      end else begin
         state  <= state_nxt;
         mask_q <= mask_nxt;
         cnt    <= cnt_nxt;
         owner  <= owner_nxt;
         ptr    <= ptr_nxt;
         gnt0   <= gnt0_nxt;
         gnt1   <= gnt1_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask_q;
      cnt_nxt   = cnt;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = BURST;
               owner_nxt = win1;
               mask_nxt  = win1 ? mask1 : mask0;
               cnt_nxt   = win1 ? len1 : len0;
               gnt0_nxt  = !win1;
               gnt1_nxt  = win1;
            end
         end
         BURST: begin
            // hold freezes the burst entirely; the count only moves on applied cycles.
            if (!hold) begin
               if (cnt == '0) begin
                  state_nxt = IDLE;
                  ptr_nxt   = !owner;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign T    = (state == BURST && !hold) ? mask_q : '0;
   assign busy = (state == BURST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Q <= '0;
      end else begin
         Q <= Q ^ T;
      end
   end

   a_one_grant: assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
   a_grant_in_burst: assert property (@(posedge clk) disable iff (reset) (gnt0 || gnt1) |-> busy);

endmodule

// File: tb/tb_tff_toggle_arb.sv
// Bench for tff_toggle_arb: directed scenarios with constant expectations and a
// randomized run checked against a burst-level reference model.
module tb_tff_toggle_arb;

   localparam int W = 4;
   localparam int L = 3;

   logic         clk;
   logic         reset;
   logic         req0;
   logic [W-1:0] mask0;
   logic [L-1:0] len0;
   logic         req1;
   logic [W-1:0] mask1;
   logic [L-1:0] len1;
   logic         hold;
   logic         gnt0;
   logic         gnt1;
   logic [W-1:0] t;
   logic [W-1:0] q;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a burst is "who owns it, which mask, how many applied cycles remain".
   logic [W-1:0] m_q;
   logic [W-1:0] m_mask;
   logic         m_busy;
   logic         m_first;
   logic         m_who;
   logic         m_pref;
   int           m_rem;

   tff_toggle_arb #(.WIDTH(W), .LENW(L)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .mask0(mask0), .len0(len0),
      .req1(req1), .mask1(mask1), .len1(len1),
      .hold(hold), .gnt0(gnt0), .gnt1(gnt1),
      .T(t), .Q(q), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_q = '0; m_mask = '0; m_busy = 1'b0; m_first = 1'b0;
      m_who = 1'b0; m_pref = 1'b0; m_rem = 0;
   endtask

   // Advance the model with the inputs currently driven, then one clock.
   task automatic tick();
      logic [W-1:0] applied;
      if (reset) begin
         model_reset();
      end else begin
         applied = (m_busy && !hold) ? m_mask : '0;
         m_q = m_q ^ applied;
         if (m_busy) begin
            m_first = 1'b0;
            if (!hold) begin
               m_rem = m_rem - 1;
               if (m_rem == 0) begin
                  m_busy = 1'b0;
                  m_pref = !m_who;
               end
            end
         end else if (req0 || req1) begin
            m_who   = (req0 && req1) ? m_pref : req1;
            m_mask  = m_who ? mask1 : mask0;
            m_rem   = (m_who ? int'(len1) : int'(len0)) + 1;
            m_busy  = 1'b1;
            m_first = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
      mask0 = '0; mask1 = '0; len0 = '0; len1 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         #1;
         n_tests++;
         if (q !== 4'b0000 || t !== 4'b0000 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d got q=%b t=%b busy=%b g0=%b g1=%b want all 0", k, q, t, busy, gnt0, gnt1);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      req0 = 1'b1; mask0 = 4'b0101; len0 = '0;
      tick();
      req0 = 1'b0;
      #1;
      n_tests++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || t !== 4'b0101 || busy !== 1'b1 || q !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_burst got g0=%b g1=%b t=%b busy=%b q=%b want 1 0 0101 1 0000", gnt0, gnt1, t, busy, q);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         #1;
         n_tests++;
         if (gnt0 !== 1'b0 || t !== 4'b0000 || busy !== 1'b0 || q !== 4'b0101) begin
            n_fail++;
            $display("FAIL single_after cyc=%0d got g0=%b t=%b busy=%b q=%b want 0 0000 0 0101", k, gnt0, t, busy, q);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      int p;
      int o;
      logic [W-1:0] m;
      logic [W-1:0] e_t;
      logic [W-1:0] e_q;
      logic e_b;
      logic e_g0;
      logic e_g1;
      do_reset();
      req0 = 1'b1; req1 = 1'b1; mask0 = 4'b0001; mask1 = 4'b0010; len0 = 3'd1; len1 = 3'd1;
      for (int k = 0; k <= 12; k++) begin
         #1;
         if (k == 0) begin
            e_b = 1'b0; e_t = '0; e_q = '0; e_g0 = 1'b0; e_g1 = 1'b0;
         end else begin
            p = (k - 1) % 3;
            o = ((k - 1) / 3) % 2;
            m = (o == 1) ? 4'b0010 : 4'b0001;
            e_b  = (p < 2);
            e_t  = (p < 2) ? m : 4'b0000;
            e_q  = (p == 1) ? m : 4'b0000;
            e_g0 = (p == 0) && (o == 0);
            e_g1 = (p == 0) && (o == 1);
         end
         n_tests++;
         if (busy !== e_b || t !== e_t || q !== e_q || gnt0 !== e_g0 || gnt1 !== e_g1) begin
            n_fail++;
            $display("FAIL round_robin cyc=%0d got b=%b t=%b q=%b g=%b%b want b=%b t=%b q=%b g=%b%b",
                     k, busy, t, q, gnt0, gnt1, e_b, e_t, e_q, e_g0, e_g1);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_hold();
      int n_busy = 0;
      int n_tog  = 0;
      do_reset();
      req1 = 1'b1; mask1 = 4'b1111; len1 = 3'd3; hold = 1'b1;
      tick();
      req1 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         hold = (k == 2 || k == 3);
         #1;
         if (busy === 1'b1) n_busy++;
         if (t !== 4'b0000) n_tog++;
         if (k == 1) begin
            n_tests++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_grant got g0=%b g1=%b want 0 1", gnt0, gnt1);
            end
         end
         if (hold && busy === 1'b1) begin
            n_tests++;
            if (t !== 4'b0000) begin
               n_fail++;
               $display("FAIL hold_t_zero cyc=%0d got t=%b want 0000", k, t);
            end
         end
         tick();
      end
      hold = 1'b0;
      #1;
      n_tests++;
      if (n_busy != 6 || n_tog != 4 || q !== 4'b0000) begin
         n_fail++;
         $display("FAIL hold_totals got busy_cycles=%0d toggles=%0d q=%b want 6 4 0000", n_busy, n_tog, q);
      end
   endtask

   task automatic test_long_burst();
      int n_busy = 0;
      int n_tog  = 0;
      do_reset();
      req0 = 1'b1; mask0 = 4'b1000; len0 = 3'd7;
      tick();
      req0 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (busy === 1'b1) n_busy++;
         if (t !== 4'b0000) n_tog++;
         n_tests++;
         if (busy !== (k <= 8) || q[3] !== ((k <= 8) ? logic'((k - 1) % 2) : 1'b0)) begin
            n_fail++;
            $display("FAIL long_burst cyc=%0d got busy=%b q3=%b want busy=%b", k, busy, q[3], (k <= 8));
         end
         tick();
      end
      n_tests++;
      if (n_busy != 8 || n_tog != 8 || q !== 4'b0000) begin
         n_fail++;
         $display("FAIL long_totals got busy_cycles=%0d toggles=%0d q=%b want 8 8 0000", n_busy, n_tog, q);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      // Serve requester 0 once so the pointer favours requester 1 before the abort.
      req0 = 1'b1; mask0 = 4'b0001; len0 = '0;
      tick();
      req0 = 1'b0;
      tick();
      tick();
      req0 = 1'b1; mask0 = 4'b1111; len0 = 3'd7;
      tick();
      req0 = 1'b0;
      tick();
      tick();
      #1;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_precond got busy=%b want 1", busy);
      end
      #1;
      reset = 1'b1;
      #1;
      n_tests++;
      if (q !== 4'b0000 || t !== 4'b0000 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got q=%b t=%b busy=%b g0=%b g1=%b want all 0", q, t, busy, gnt0, gnt1);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; len0 = '0; len1 = '0; mask0 = 4'b0011; mask1 = 4'b1100;
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || t !== 4'b0011) begin
         n_fail++;
         $display("FAIL post_reset_tie got g0=%b g1=%b t=%b want 1 0 0011", gnt0, gnt1, t);
      end
      tick();
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] e_t;
      logic e_g0;
      logic e_g1;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         req0  = ($urandom_range(0, 2) == 0);
         req1  = ($urandom_range(0, 2) == 0);
         mask0 = W'($urandom_range(0, 15));
         mask1 = W'($urandom_range(0, 15));
         len0  = L'($urandom_range(0, 7));
         len1  = L'($urandom_range(0, 7));
         hold  = ($urandom_range(0, 3) == 0);
         #1;
         e_t  = (m_busy && !hold) ? m_mask : '0;
         e_g0 = m_busy && m_first && !m_who;
         e_g1 = m_busy && m_first && m_who;
         n_tests++;
         if (t !== e_t || q !== m_q || busy !== m_busy || gnt0 !== e_g0 || gnt1 !== e_g1) begin
            n_fail++;
            $display("FAIL random cyc=%0d got t=%b q=%b b=%b g=%b%b want t=%b q=%b b=%b g=%b%b",
                     k, t, q, busy, gnt0, gnt1, e_t, m_q, m_busy, e_g0, e_g1);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_hold();
      test_long_burst();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tff_toggle_arb.md
TFF_TOGGLE_ARB -- requirements
Module: tff_toggle_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the internal T flip-flop bank.
REQ-002 The block SHALL have parameter LENW, default 3, giving the burst-length field width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port req0, input, 1, toggle request from requester 0.
REQ-006 Port mask0, input, WIDTH, requester 0 toggle mask.
REQ-007 Port len0, input, LENW, requester 0 burst length minus one.
REQ-008 Ports req1, mask1 and len1 SHALL mirror REQ-005..REQ-007 for requester 1.
REQ-009 Port gnt0, output, 1, one-cycle grant pulse to requester 0.
REQ-010 Port gnt1, output, 1, one-cycle grant pulse to requester 1.
REQ-011 Port hold, input, 1, pauses an active burst.
REQ-012 Port T, output, WIDTH, toggle enables currently applied to the bank.
REQ-013 Port Q, output, WIDTH, T flip-flop bank state.
REQ-014 Port busy, output, 1, high while a burst is in progress.

Function
REQ-015 The FSM SHALL have two states, IDLE and BURST.
REQ-016 In IDLE, at an edge with req0 or req1 sampled high, the FSM SHALL move to BURST and latch the winner's mask, len and identity.
REQ-017 Arbitration SHALL be round-robin: when both requests are high, the winner SHALL be the requester not served last; after reset, requester 0 wins the first tie.
REQ-018 When only one request is high, that requester SHALL win regardless of the round-robin pointer.
REQ-019 gnt0/gnt1 SHALL be high for exactly the first BURST cycle of the winner's burst, and never both at once.
REQ-020 In BURST with hold low, T SHALL equal the latched mask; otherwise T SHALL be all zeros.
REQ-021 At every edge, Q SHALL become Q XOR T, so each bit toggles only when its T bit is 1.
REQ-022 A burst SHALL apply the mask for len+1 non-held cycles; a down-counter loaded with len SHALL decrement on each non-held BURST edge.
REQ-023 At the edge where the counter is 0 and hold is low, the FSM SHALL return to IDLE and the pointer SHALL move to the other requester.
REQ-024 hold high in BURST SHALL freeze the counter and state, and force T to 0; hold in IDLE SHALL have no effect.
REQ-025 Requests and mask/len changes during BURST SHALL be ignored; a request still high in IDLE SHALL be re-arbitrated.
REQ-026 At least one IDLE cycle SHALL occur between consecutive bursts.
REQ-027 A zero mask SHALL still run a full burst with Q unchanged.
REQ-028 busy SHALL be high exactly when the state is BURST.
REQ-029 With len = 2^LENW-1, the burst SHALL last 2^LENW non-held cycles, with no counter wrap.

Reset
REQ-030 While reset is high, regardless of clk, the block SHALL asynchronously force: state IDLE, Q=0, T=0, gnt0=gnt1=0, busy=0, counter=0, pointer favouring requester 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no further toggles; after release, the block SHALL start in IDLE.

Verification
REQ-032 Reset pulse, no requests -> Q=0, T=0, busy=0, gnt0=gnt1=0 held.
REQ-033 req0=1, mask0=0101, len0=0 for one cycle -> gnt0 for 1 cycle, T=0101 for 1 cycle, Q=0101, then IDLE.
REQ-034 req0 and req1 both high continuously, mask0=0001, mask1=0010, len=1 -> grant order 0,1,0,1; each T burst 2 cycles; one IDLE cycle between bursts; Q returns to 0000 after each burst.
REQ-035 req1, mask1=1111, len1=3, hold high for 2 cycles mid-burst -> 4 toggle cycles total, T=0 during hold, busy high for 6 cycles, final Q=0000.
REQ-036 Reset asserted between clock edges during a len=7 burst -> Q, T, busy, gnt go to 0 immediately; the first request after release is granted to requester 0.
REQ-037 len0=7, mask0=1000 -> 8 toggle cycles, Q[3] ends at 0, busy drops on cycle 9.
